// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared state encoding and fixed playfield geometry for Pong.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam logic [9:0] c_wall_left   = 10'd10;
   localparam logic [9:0] c_wall_right  = 10'd630;
   localparam logic [9:0] c_wall_top    = 10'd10;
   localparam logic [9:0] c_wall_bottom = 10'd470;
   localparam logic [9:0] c_face_left   = 10'd40;
   localparam logic [9:0] c_face_right  = 10'd600;
   localparam logic [9:0] c_centre_x    = 10'd314;
   localparam logic [9:0] c_centre_y    = 10'd234;
   localparam logic [9:0] c_pad_init    = 10'd190;

endpackage
`default_nettype wire

// File: rtl/paddle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_ctrl
// Description : Saturating up/down paddle tracker, advanced once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int PAD_H    = 100,
   parameter int PAD_STEP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_down,
   output logic [9:0] o_pos
);

   localparam logic [10:0] c_min  = 11'(c_wall_top);
   localparam logic [10:0] c_max  = 11'(c_wall_bottom) - 11'(PAD_H);
   localparam logic [10:0] c_step = 11'(PAD_STEP);

   logic [9:0]  r_pos;
   logic [10:0] w_pos;

   assign w_pos = {1'b0, r_pos};

   // Opposing buttons cancel, so only a lone press moves the paddle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pos <= c_pad_init;
      end else if (i_tick && i_en && (i_up ^ i_down)) begin
         if (i_up)
            r_pos <= (w_pos <= c_min + c_step) ? 10'(c_min) : 10'(w_pos - c_step);
         else
            r_pos <= (w_pos + c_step >= c_max) ? 10'(c_max) : 10'(w_pos + c_step);
      end
   end

   assign o_pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/pong_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_ctrl
// Description : Per-frame Pong sequencer: ball motion, paddles, lives, game FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int BALL_SIZE    = 12,
   parameter int BALL_STEP    = 2,
   parameter int PAD_H        = 100,
   parameter int PAD_STEP     = 4,
   parameter int LIVES_INIT   = 7,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start,
   input  logic       btn_iu,
   input  logic       btn_id,
   input  logic       btn_du,
   input  logic       btn_dd,
   output logic [9:0] posx,
   output logic [9:0] posy,
   output logic [9:0] posbarraiy,
   output logic [9:0] posbarrady,
   output logic [2:0] vidasi,
   output logic [2:0] vidasd,
   output logic [2:0] game_state,
   output logic       game_over
);

   localparam int          c_cnt_w    = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SERVE_FRAMES - 1);
   localparam logic [10:0] c_size     = 11'(BALL_SIZE);
   localparam logic [10:0] c_step     = 11'(BALL_STEP);
   localparam logic [10:0] c_padh     = 11'(PAD_H);
   localparam logic [9:0]  c_step10   = 10'(BALL_STEP);

   state_t             r_state, w_state_nxt;
   logic [9:0]         r_posx, r_posy, w_posx_nxt, w_posy_nxt;
   logic               r_dx, r_dy, w_dx_nxt, w_dy_nxt;   // dx=1 right, dy=1 down
   logic [2:0]         r_lives_l, r_lives_r, w_lives_l_nxt, w_lives_r_nxt;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
   logic               r_loser_left, w_loser_left_nxt;
   logic               r_game_over;
   logic [9:0]         w_pad_l, w_pad_r;
   logic               w_pad_en;

   paddle_ctrl #(.PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad_l (
      .clk(clk), .rst(reset), .i_tick(frame_tick), .i_en(w_pad_en),
      .i_up(btn_iu), .i_down(btn_id), .o_pos(w_pad_l)
   );

   paddle_ctrl #(.PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad_r (
      .clk(clk), .rst(reset), .i_tick(frame_tick), .i_en(w_pad_en),
      .i_up(btn_du), .i_down(btn_dd), .o_pos(w_pad_r)
   );

   assign w_pad_en = (r_state == SERVE) || (r_state == PLAY);

   // Ball tests run in 11 bits; paddle overlap uses pre-update paddle values.
   logic [10:0] w_x, w_y, w_pl, w_pr;
   logic        w_y_top, w_y_bot, w_hit_l, w_hit_r, w_miss_l, w_miss_r, w_miss;
   logic [2:0]  w_lives_sel, w_lives_dec;

   assign w_x  = {1'b0, r_posx};
   assign w_y  = {1'b0, r_posy};
   assign w_pl = {1'b0, w_pad_l};
   assign w_pr = {1'b0, w_pad_r};

   assign w_y_top  = !r_dy && (w_y <= 11'(c_wall_top) + c_step);
   assign w_y_bot  =  r_dy && (w_y + c_size >= 11'(c_wall_bottom) - c_step);
   assign w_hit_l  = !r_dx && (w_x >= 11'(c_face_left)) && (w_x - c_step <= 11'(c_face_left))
                     && (w_y + c_size >= w_pl) && (w_y <= w_pl + c_padh);
   assign w_hit_r  =  r_dx && (w_x + c_size <= 11'(c_face_right))
                     && (w_x + c_size + c_step >= 11'(c_face_right))
                     && (w_y + c_size >= w_pr) && (w_y <= w_pr + c_padh);
   assign w_miss_l = !r_dx && (w_x <= 11'(c_wall_left) + c_step);
   assign w_miss_r =  r_dx && (w_x + c_size >= 11'(c_wall_right) - c_step);
   assign w_miss   = !w_hit_l && !w_hit_r && (w_miss_l || w_miss_r);

   assign w_lives_sel = r_loser_left ? r_lives_l : r_lives_r;
   assign w_lives_dec = (w_lives_sel == 3'd0) ? 3'd0 : w_lives_sel - 3'd1;

   always_comb begin
      w_state_nxt      = r_state;
      w_posx_nxt       = r_posx;
      w_posy_nxt       = r_posy;
      w_dx_nxt         = r_dx;
      w_dy_nxt         = r_dy;
      w_lives_l_nxt    = r_lives_l;
      w_lives_r_nxt    = r_lives_r;
      w_cnt_nxt        = r_cnt;
      w_loser_left_nxt = r_loser_left;
      if (frame_tick) begin
         case (r_state)
            IDLE: if (start) w_state_nxt = SERVE;
            SERVE: begin
               w_posx_nxt = c_centre_x;
               w_posy_nxt = c_centre_y;
               if (r_cnt == c_cnt_last) begin
                  w_state_nxt = PLAY;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            PLAY: begin
               if (w_miss) begin
                  w_state_nxt      = POINT;
                  w_loser_left_nxt = w_miss_l;
               end else begin
                  if (w_y_top) begin
                     w_posy_nxt = c_wall_top;
                     w_dy_nxt   = 1'b1;
                  end else if (w_y_bot) begin
                     w_posy_nxt = 10'(c_wall_bottom - 10'(BALL_SIZE));
                     w_dy_nxt   = 1'b0;
                  end else begin
                     w_posy_nxt = r_dy ? r_posy + c_step10 : r_posy - c_step10;
                  end
                  if (w_hit_l) begin
                     w_posx_nxt = c_face_left;
                     w_dx_nxt   = 1'b1;
                  end else if (w_hit_r) begin
                     w_posx_nxt = 10'(c_face_right - 10'(BALL_SIZE));
                     w_dx_nxt   = 1'b0;
                  end else begin
                     w_posx_nxt = r_dx ? r_posx + c_step10 : r_posx - c_step10;
                  end
               end
            end
            POINT: begin
               if (r_loser_left) w_lives_l_nxt = w_lives_dec;
               else              w_lives_r_nxt = w_lives_dec;
               w_dx_nxt    = !r_loser_left;
               w_posx_nxt  = c_centre_x;
               w_posy_nxt  = c_centre_y;
               w_state_nxt = (w_lives_dec == 3'd0) ? OVER : SERVE;
            end
            OVER: begin
               if (start) begin
                  w_lives_l_nxt = 3'(LIVES_INIT);
                  w_lives_r_nxt = 3'(LIVES_INIT);
                  w_state_nxt   = SERVE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_posx       <= c_centre_x;
         r_posy       <= c_centre_y;
         r_dx         <= 1'b1;
         r_dy         <= 1'b1;
         r_lives_l    <= 3'(LIVES_INIT);
         r_lives_r    <= 3'(LIVES_INIT);
         r_cnt        <= '0;
         r_loser_left <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_posx       <= w_posx_nxt;
         r_posy       <= w_posy_nxt;
         r_dx         <= w_dx_nxt;
         r_dy         <= w_dy_nxt;
         r_lives_l    <= w_lives_l_nxt;
         r_lives_r    <= w_lives_r_nxt;
         r_cnt        <= w_cnt_nxt;
         r_loser_left <= w_loser_left_nxt;
         r_game_over  <= (w_state_nxt == OVER);
      end
   end

   assign posx       = r_posx;
   assign posy       = r_posy;
   assign posbarraiy = w_pad_l;
   assign posbarrady = w_pad_r;
   assign vidasi     = r_lives_l;
   assign vidasd     = r_lives_r;
   assign game_state = r_state;
   assign game_over  = r_game_over;

endmodule
`default_nettype wire
